conv_window_3x3: RTL and testbench
==================================

Name: conv_window_3x3

Overview:
- Streaming 3x3 sliding-window generator that sits directly downstream of the zero-padding stage and feeds the 3x3 convolution datapath.
- Accepts the padded image one 16-bit pixel per beat, in raster order: channel-major, then row, then column.
- Emits one 9-pixel window per valid output position, using two line buffers and a 3x3 register array.
- Valid/ready handshakes on both sides; full throughput is one window per clock.

Parameters:
- DATA_WIDTH, 16, pixel width in bits; fixed to match the padding stage.
- K, 1, number of channels per frame.
- H, 1, unpadded image height; the input carries H+2 rows.
- W, 1, unpadded image width; the input carries W+2 columns.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH  padded pixel.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the block accepts in_data this cycle.
- out_window  output  [0:9*DATA_WIDTH-1]  window; element r*3+c occupies bits [(r*3+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the top row, c=0 the left column.
- out_valid  output  1  out_window is valid.
- out_ready  input  1  downstream accepts the window.
- out_chan_last  output  1  marks the last window (row H-1, col W-1) of the current channel.
- out_frame_last  output  1  marks the last window of channel K-1.

Behaviour:
- Reset (async, active-high): out_valid=0, out_window=0, out_chan_last=0, out_frame_last=0; col, row and chan counters = 0; in_ready=1 once reset deasserts. Line-buffer and window-register contents need no reset.
- Accept rule: a pixel is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This gives a single registered output stage with no combinational path from in_valid to out_valid.
- Counters:
  - col runs 0..W+1 and advances on each accept.
  - At W+1, col wraps to 0 and row advances (0..H+1).
  - At row H+1, col W+1, row wraps to 0 and chan advances (0..K-1).
  - At chan K-1, chan wraps to 0 and the next frame starts with no gap cycle.
- Datapath on accept:
  - Each window row shifts left by one.
  - The new right column is {linebuf1[col], linebuf0[col], in_data} for rows 0, 1, 2.
  - Then linebuf1[col] <= linebuf0[col] and linebuf0[col] <= in_data.
- Emission: if the accepted pixel has row>=2 and col>=2, then on the next cycle out_valid=1 and out_window holds the window whose top-left pixel is (row-2, col-2).
- Flags: out_chan_last=1 when the accepted pixel is (H+1, W+1); out_frame_last=1 additionally requires chan==K-1.
- Latency: one clock from the accepting edge to out_valid.
- Count: exactly W*H windows per channel and K*W*H per frame.
- Stall: while out_valid && !out_ready, out_window and the flags hold stable and in_ready=0. No pixel is dropped or duplicated.
- out_valid drops only when (out_ready && no new window is produced this cycle).
- Simultaneous out_ready and accept: the old window retires and the new one loads in the same edge.
- Channel boundary: the line buffers are not cleared. Stale rows are never emitted, because windows require row>=2 in the new channel.
- Reset mid-frame: all state is discarded, the next accepted pixel is treated as (0,0) of channel 0, and no partial window is emitted.
- Degenerate case W=H=1: one window per channel, emitted after pixel (2,2).

Decomposition:
- Shared package cnn_pkg:
  - DATA_WIDTH=16
  - window size constant WIN=3
  - element index function idx(r,c)=r*3+c
- Sub-module line_buffer:
  - depth W+2, DATA_WIDTH wide, single write/read address (col).
  - Read-before-write, registered or distributed storage.
  - Instantiated twice.

Test Plan:
- K=1, W=H=2, pixels 0..15 streamed back-to-back with out_ready=1:
  - Windows {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}.
  - out_valid appears one cycle after pixels 10, 11, 14 and 15 are accepted.
  - The 4th window has out_chan_last=1 and out_frame_last=1.
- Same stream with out_ready held low 5 cycles after the first window:
  - in_ready=0 during the stall and out_window holds {0,1,...,10}.
  - On release, the remaining 3 windows arrive unchanged with no duplicates.
- K=2, W=H=2, channel 1 pixels 100..115:
  - 8 windows total; window 5 = {100,101,102,104,105,106,108,109,110}.
  - out_chan_last on windows 4 and 8; out_frame_last only on window 8.
- Random in_valid/out_ready gaps (50%), K=3, W=4, H=3:
  - Output matches a reference model element-for-element.
  - Exactly 36 windows.
- reset pulsed after pixel 9 of a frame, then 16 fresh pixels 0..15:
  - No window is emitted before pixel 10 of the new frame.
  - Output equals scenario 1.
- W=H=1, K=1, pixels 1..9: exactly one window {1..9}, with out_chan_last=1 and out_frame_last=1.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the 3x3 convolution front end.
// No logic and no latency of its own.
// Not involved in flow control.
package cnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int WIN        = 3;

    // Per-window side information that travels with out_window.
    typedef struct packed {
        logic chan_last;
        logic frame_last;
    } win_meta_t;

    // Flat element index inside a window: r = row from the top, c = column from the left.
    function automatic int idx(input int r, input int c);
        return r * WIN + c;
    endfunction

endpackage

// File: rtl/conv_window_3x3_line_buffer.sv
// One image line of pixel storage, addressed by column. The read is combinational and sees the old word.
// Latency: zero for the read; the write lands on the next clock edge.
// No flow control; the owner qualifies writes with wr_en.
module line_buffer #(
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic [AW-1:0]         addr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A read and a write to the same address in one cycle return the previous contents.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_3x3.sv
// Turns a padded raster stream into 3x3 windows, one window per valid output position.
// Latency: one clock from the edge that accepts a pixel to the window it completes.
// One registered output stage; in_ready is low only while a window waits for out_ready.
module conv_window_3x3 #(
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int K          = 1,
    parameter int H          = 1,
    parameter int W          = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [0:9*DATA_WIDTH-1]   out_window,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_chan_last,
    output logic                      out_frame_last
);

    import cnn_pkg::*;

    localparam int CW = $clog2(W + 2);
    localparam int RW = $clog2(H + 2);
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0] COL_MAX   = CW'(W + 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(H + 1);
    localparam logic [KW-1:0] CHAN_MAX  = KW'(K - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WIN - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(WIN - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [KW-1:0] chan;

    logic accept;
    logic emit;
    logic col_wrap;
    logic row_wrap;
    logic chan_wrap;

    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic [DATA_WIDTH-1:0] new_col [WIN];
    logic [DATA_WIDTH-1:0] win     [WIN][WIN];
    win_meta_t             meta;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign col_wrap  = (col == COL_MAX);
    assign row_wrap  = (row == ROW_MAX);
    assign chan_wrap = (chan == CHAN_MAX);
    // A window exists once the accepted pixel is its bottom-right corner.
    assign emit      = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);

    // linebuf0 holds the previous line, linebuf1 the one before it.
    line_buffer #(
        .DEPTH      (W + 2),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (CW)
    ) u_linebuf0 (
        .clk     (clk),
        .addr    (col),
        .wr_en   (accept),
        .wr_data (in_data),
        .rd_data (lb0_rd)
    );

    line_buffer #(
        .DEPTH      (W + 2),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (CW)
    ) u_linebuf1 (
        .clk     (clk),
        .addr    (col),
        .wr_en   (accept),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    assign new_col[0] = lb1_rd;
    assign new_col[1] = lb0_rd;
    assign new_col[2] = in_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            chan <= '0;
        end else if (accept) begin
            if (col_wrap) begin
                col <= '0;
                if (row_wrap) begin
                    row  <= '0;
                    chan <= chan_wrap ? '0 : chan + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // The window array only moves on accept, so it is stable for as long as a window is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][WIN-1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            meta      <= '0;
        end else if (in_ready) begin
            out_valid       <= emit;
            meta.chan_last  <= emit && row_wrap && col_wrap;
            meta.frame_last <= emit && row_wrap && col_wrap && chan_wrap;
        end
    end

    always_comb begin
        out_window = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                out_window[idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
            end
        end
    end

    assign out_chan_last  = meta.chan_last;
    assign out_frame_last = meta.frame_last;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Bench for conv_window_3x3: four instances with different geometries, checked against a frame-level window model.
module tb_conv_window_3x3;

    localparam int DW = 16;
    localparam int NW = 9 * DW;
    localparam int ND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [DW-1:0]   din   [ND];
    logic            vin   [ND];
    logic            rin   [ND];
    logic [0:NW-1]   wout  [ND];
    logic            vout  [ND];
    logic            rdy   [ND];
    logic            clast [ND];
    logic            flast [ND];

    conv_window_3x3 #(.DATA_WIDTH(DW), .K(1), .H(2), .W(2)) u_a (
        .clk(clk), .reset(reset), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rin[0]),
        .out_window(wout[0]), .out_valid(vout[0]), .out_ready(rdy[0]),
        .out_chan_last(clast[0]), .out_frame_last(flast[0]));

    conv_window_3x3 #(.DATA_WIDTH(DW), .K(2), .H(2), .W(2)) u_b (
        .clk(clk), .reset(reset), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rin[1]),
        .out_window(wout[1]), .out_valid(vout[1]), .out_ready(rdy[1]),
        .out_chan_last(clast[1]), .out_frame_last(flast[1]));

    conv_window_3x3 #(.DATA_WIDTH(DW), .K(3), .H(3), .W(4)) u_c (
        .clk(clk), .reset(reset), .in_data(din[2]), .in_valid(vin[2]), .in_ready(rin[2]),
        .out_window(wout[2]), .out_valid(vout[2]), .out_ready(rdy[2]),
        .out_chan_last(clast[2]), .out_frame_last(flast[2]));

    conv_window_3x3 #(.DATA_WIDTH(DW), .K(1), .H(1), .W(1)) u_d (
        .clk(clk), .reset(reset), .in_data(din[3]), .in_valid(vin[3]), .in_ready(rin[3]),
        .out_window(wout[3]), .out_valid(vout[3]), .out_ready(rdy[3]),
        .out_chan_last(clast[3]), .out_frame_last(flast[3]));

    int checks = 0;
    int errors = 0;

    // Scenario state
    int dut, kk, hh, ww, ph, pw;
    int gap_in, gap_out;
    bit stall_mode, timing_chk;
    int got;
    logic exp_vld;
    int pix [$];
    logic [0:NW-1] exp_w [$];
    logic exp_c [$];
    logic exp_f [$];

    task automatic check_val(input string tag, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic setup(input int d, input int k, input int h, input int w);
        dut = d; kk = k; hh = h; ww = w; ph = h + 2; pw = w + 2;
        pix.delete(); exp_w.delete(); exp_c.delete(); exp_f.delete();
        gap_in = 0; gap_out = 0; stall_mode = 1'b0; timing_chk = 1'b0;
    endtask

    // Every output position of every channel of every complete frame in pix, in raster order.
    task automatic build_expected();
        int frames, base;
        logic [0:NW-1] w;
        frames = pix.size() / (kk * ph * pw);
        for (int f = 0; f < frames; f++) begin
            for (int k = 0; k < kk; k++) begin
                base = (f * kk + k) * ph * pw;
                for (int r = 0; r < hh; r++) begin
                    for (int c = 0; c < ww; c++) begin
                        for (int i = 0; i < 3; i++) begin
                            for (int j = 0; j < 3; j++) begin
                                w[(i*3+j)*DW +: DW] = DW'(pix[base + (r+i)*pw + (c+j)]);
                            end
                        end
                        exp_w.push_back(w);
                        exp_c.push_back(r == hh-1 && c == ww-1);
                        exp_f.push_back(r == hh-1 && c == ww-1 && k == kk-1);
                    end
                end
            end
        end
    endtask

    task automatic drive_pixels(input int budget);
        int i, cyc, p;
        logic acc;
        i = 0; cyc = 0;
        while (i < pix.size() && cyc < budget) begin
            if (gap_in == 0 || $urandom_range(99) >= gap_in) begin
                vin[dut] = 1'b1;
                din[dut] = DW'(pix[i]);
            end else begin
                vin[dut] = 1'b0;
                din[dut] = DW'($urandom);
            end
            @(negedge clk);
            acc = vin[dut] && rin[dut];
            if (timing_chk) check_val("vld_timing", NW'(vout[dut]), NW'(exp_vld));
            p = i % (ph * pw);
            exp_vld = acc && (p / pw >= 2) && (p % pw >= 2);
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        vin[dut] = 1'b0;
        check_val("pixels_accepted", NW'(i), NW'(pix.size()));
        if (timing_chk) begin
            @(negedge clk);
            check_val("vld_timing_last", NW'(vout[dut]), NW'(exp_vld));
        end
    endtask

    task automatic collect_windows(input int total, input int budget);
        int cyc, stall_seen;
        cyc = 0; stall_seen = 0;
        while (got < total && cyc < budget) begin
            @(negedge clk);
            if (vout[dut]) begin
                if (rdy[dut]) begin
                    check_val($sformatf("win%0d", got), wout[dut], exp_w[0]);
                    check_val($sformatf("chan_last%0d", got), NW'(clast[dut]), NW'(exp_c[0]));
                    check_val($sformatf("frame_last%0d", got), NW'(flast[dut]), NW'(exp_f[0]));
                    void'(exp_w.pop_front());
                    void'(exp_c.pop_front());
                    void'(exp_f.pop_front());
                    got++;
                end else begin
                    check_val("hold_win", wout[dut], exp_w[0]);
                    check_val("hold_chan_last", NW'(clast[dut]), NW'(exp_c[0]));
                    check_val("stall_in_ready", NW'(rin[dut]), '0);
                    stall_seen++;
                end
            end
            @(posedge clk); #1;
            if (stall_mode) rdy[dut] = (stall_seen >= 5);
            else if (gap_out != 0) rdy[dut] = ($urandom_range(99) >= gap_out);
            else rdy[dut] = 1'b1;
            cyc++;
        end
    endtask

    task automatic run_stream(input int budget);
        int total;
        total = exp_w.size();
        got = 0;
        exp_vld = 1'b0;
        rdy[dut] = stall_mode ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        fork
            drive_pixels(budget);
            collect_windows(total, budget);
        join
        check_val("win_count", NW'(got), NW'(total));
        rdy[dut] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("no_extra", NW'(vout[dut]), '0);
        end
        @(posedge clk); #1;
    endtask

    task automatic scenario_basic();
        setup(0, 1, 2, 2);
        for (int i = 0; i < 16; i++) pix.push_back(i);
        build_expected();
        timing_chk = 1'b1;
        run_stream(400);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < ND; d++) begin
            vin[d] = 1'b0; din[d] = '0; rdy[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check_val($sformatf("rst_valid%0d", d), NW'(vout[d]), '0);
            check_val($sformatf("rst_window%0d", d), wout[d], '0);
            check_val($sformatf("rst_chan_last%0d", d), NW'(clast[d]), '0);
            check_val($sformatf("rst_frame_last%0d", d), NW'(flast[d]), '0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) check_val($sformatf("rst_in_ready%0d", d), NW'(rin[d]), NW'(1));
        @(posedge clk); #1;

        // Back-to-back 4x4 padded frame
        scenario_basic();

        // Same stream, first window stalled for five cycles
        setup(0, 1, 2, 2);
        for (int i = 0; i < 16; i++) pix.push_back(i);
        build_expected();
        stall_mode = 1'b1;
        run_stream(400);

        // Two channels, the second offset by 100
        setup(1, 2, 2, 2);
        for (int i = 0; i < 16; i++) pix.push_back(i);
        for (int i = 0; i < 16; i++) pix.push_back(100 + i);
        build_expected();
        timing_chk = 1'b1;
        run_stream(400);

        // Random data with random gaps on both sides
        setup(2, 3, 3, 4);
        for (int i = 0; i < 3 * 5 * 6; i++) pix.push_back(int'($urandom_range(65535)));
        build_expected();
        gap_in = 50; gap_out = 50;
        run_stream(5000);

        // Reset after pixel 9 of a frame, then a complete fresh frame
        setup(0, 1, 2, 2);
        for (int i = 0; i < 10; i++) pix.push_back(i);
        timing_chk = 1'b1;
        run_stream(400);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("midrst_valid", NW'(vout[0]), '0);
        check_val("midrst_in_ready", NW'(rin[0]), NW'(1));
        @(posedge clk); #1;
        scenario_basic();

        // Smallest geometry: a single window per frame
        setup(3, 1, 1, 1);
        for (int i = 1; i <= 9; i++) pix.push_back(i);
        build_expected();
        timing_chk = 1'b1;
        run_stream(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
